// File: rtl/jk_pkg.sv
// Shared definitions for the JK up/down counter.
// - JK excitation codes, ordered {J, K}
// - Default counter width and modulus
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 10;

endpackage

// File: rtl/jk_stage.sv
// One JK flip-flop.
// Ports:
//   clk - rising-edge clock
//   clr - asynchronous active-low clear (Q -> 0)
//   J,K - excitation: 00 hold, 01 reset, 10 set, 11 toggle
//   Q   - stored bit
//   Qn  - complement of Q
module jk_stage
    import jk_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qn
);

    logic q_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q <= 1'b0;
        end else begin
            unique case ({J, K})
                JK_HOLD:   q_q <= q_q;
                JK_RESET:  q_q <= 1'b0;
                JK_SET:    q_q <= 1'b1;
                JK_TOGGLE: q_q <= ~q_q;
                default:   q_q <= q_q;
            endcase
        end
    end

    assign Q  = q_q;
    assign Qn = ~q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK flip-flops.
// The next count is computed here and delivered to the stages only via
// per-bit J/K excitation; the stages never see the next count directly.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-low clear
//   en   - count enable
//   up   - direction: 1 up, 0 down
//   load - synchronous parallel load (priority over en)
//   D    - load value (out-of-range values load 0)
//   Q    - present count
//   J, K - excitation currently applied to each stage
//   tc   - terminal count for the current direction
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             tc
);

    // Modulus is widened by one bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] n_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_stage u_stage (
            .clk (clk),
            .clr (clr),
            .J   (J[i]),
            .K   (K[i]),
            .Q   (q[i]),
            .Qn  (qn[i])
        );
    end

    always_comb begin
        n_cnt = q;
        if (load) begin
            n_cnt = ({1'b0, D} < ModExt) ? D : '0;
        end else if (en) begin
            if (up) begin
                // '>=' also sends any illegal count back to 0
                n_cnt = (q >= MaxVal) ? '0 : q + One;
            end else if (q == '0) begin
                n_cnt = MaxVal;
            end else if (q > MaxVal) begin
                n_cnt = '0;
            end else begin
                n_cnt = q - One;
            end
        end
    end

    // Set only bits that must rise, reset only bits that must fall; never toggle.
    assign J  = qn & n_cnt;
    assign K  = q & ~n_cnt;
    assign Q  = q;
    assign tc = en & ~load & ((up & (q == MaxVal)) | (~up & (q == '0)));

endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;

    logic       clk;
    logic       clr;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] D;
    logic [3:0] Q;
    logic [3:0] J;
    logic [3:0] K;
    logic       tc;

    int errors;
    int checks;

    jk_updown_counter #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .up   (up),
        .load (load),
        .D    (D),
        .Q    (Q),
        .J    (J),
        .K    (K),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; D = 4'd0;
        #1 clr = 1'b0;
        #1;
        checks++;
        if (Q !== 4'd0) begin
            errors++; $display("FAIL reset_async: Q=%0d expected 0", Q);
        end
        tick();
        checks++;
        if (Q !== 4'd0) begin
            errors++; $display("FAIL reset_edge_ignored: Q=%0d expected 0", Q);
        end
        checks++;
        if (J !== 4'b0001 || K !== 4'b0000 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_excitation: J=%b K=%b tc=%b expected J=0001 K=0000 tc=0",
                     J, K, tc);
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q  [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        logic       exp_tc [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (Q !== exp_q[i] || tc !== exp_tc[i]) begin
                errors++;
                $display("FAIL count_up[%0d]: Q=%0d tc=%b expected Q=%0d tc=%b",
                         i, Q, tc, exp_q[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_q  [9] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        logic       exp_tc [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        load = 1'b1; D = 4'd7;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        checks++;
        if (Q !== 4'd7 || tc !== 1'b0) begin
            errors++; $display("FAIL down_load7: Q=%0d tc=%b expected Q=7 tc=0", Q, tc);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (Q !== exp_q[i] || tc !== exp_tc[i]) begin
                errors++;
                $display("FAIL count_down[%0d]: Q=%0d tc=%b expected Q=%0d tc=%b",
                         i, Q, tc, exp_q[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_load();
        en = 1'b0; load = 1'b1; D = 4'd12;
        tick();
        checks++;
        if (Q !== 4'd0) begin
            errors++; $display("FAIL load_out_of_range: Q=%0d expected 0", Q);
        end
        en = 1'b1; up = 1'b1; D = 4'd3;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++; $display("FAIL load_tc_masked: tc=%b expected 0", tc);
        end
        tick();
        checks++;
        if (Q !== 4'd3) begin
            errors++; $display("FAIL load_over_en: Q=%0d expected 3", Q);
        end
        D = 4'd9;
        tick();
        checks++;
        if (Q !== 4'd9) begin
            errors++; $display("FAIL load_max: Q=%0d expected 9", Q);
        end
        D = 4'd10;
        tick();
        checks++;
        if (Q !== 4'd0) begin
            errors++; $display("FAIL load_modulus: Q=%0d expected 0", Q);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_hold();
        load = 1'b1; D = 4'd5;
        tick();
        load = 1'b0; en = 1'b0; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Q !== 4'd5 || J !== 4'b0000 || K !== 4'b0000 || tc !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: Q=%0d J=%b K=%b tc=%b expected Q=5 J=0000 K=0000 tc=0",
                         i, Q, J, K, tc);
            end
        end
    endtask

    task automatic test_excitation();
        load = 1'b1; D = 4'd7;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        checks++;
        if (J !== 4'b1000 || K !== 4'b0111) begin
            errors++; $display("FAIL excite_7_to_8: J=%b K=%b expected J=1000 K=0111", J, K);
        end
        tick();
        checks++;
        if (Q !== 4'd8) begin
            errors++; $display("FAIL excite_result: Q=%0d expected 8", Q);
        end
    endtask

    task automatic test_direction_change();
        load = 1'b1; D = 4'd3;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (Q !== 4'd4) begin
            errors++; $display("FAIL dir_up: Q=%0d expected 4", Q);
        end
        up = 1'b0;
        tick();
        checks++;
        if (Q !== 4'd3) begin
            errors++; $display("FAIL dir_down_no_dead_cycle: Q=%0d expected 3", Q);
        end
    endtask

    task automatic test_async_clr();
        load = 1'b1; D = 4'd4;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #5;
        clr = 1'b0;
        #1;
        checks++;
        if (Q !== 4'd0) begin
            errors++; $display("FAIL clr_mid_cycle: Q=%0d expected 0", Q);
        end
        #2;
        clr = 1'b1;
        tick();
        checks++;
        if (Q !== 4'd1) begin
            errors++; $display("FAIL clr_resume: Q=%0d expected 1", Q);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_hold();
        test_excitation();
        test_direction_change();
        test_async_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
